// File: rtl/serial_adder_if.sv
// serial_adder handshake/data bundle.
// ovf exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ci;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             co;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf;

   modport master (
      output start, a, b, ci,
      input  busy, done, sum, co, ovf
   );
   modport slave (
      input  start, a, b, ci,
      output busy, done, sum, co, ovf
   );
`else
   modport master (
      output start, a, b, ci,
      input  busy, done, sum, co
   );
   modport slave (
      input  start, a, b, ci,
      output busy, done, sum, co
   );
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus carry FF, LSB first.
// Optional signed-overflow flag under SERIAL_ADDER_OVF_EN.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input logic           clk,
   input logic           rst,
   serial_adder_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] sum_r;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             fa_s;
   logic             fa_c;
   logic             last;

   assign fa_s = a_sr[0] ^ b_sr[0] ^ carry;
   assign fa_c = (a_sr[0] & b_sr[0]) |
                 (a_sr[0] & carry) |
                 (b_sr[0] & carry);
   assign last = (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (bus.start) state_nxt = SHIFT;
         SHIFT:   if (last)      state_nxt = DONE;
         DONE:                   state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.busy = 1'b0;
      bus.done = 1'b0;
      unique case (1'b1)
         (state == SHIFT): bus.busy = 1'b1;
         (state == DONE):  bus.done = 1'b1;
         default:          ;
      endcase
   end

   // carry doubles as co: it is frozen outside SHIFT, reloaded from ci at load
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr  <= '0;
         b_sr  <= '0;
         sum_r <= '0;
         carry <= 1'b0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               a_sr  <= bus.a;
               b_sr  <= bus.b;
               carry <= bus.ci;
               cnt   <= '0;
            end
            SHIFT: begin
               a_sr  <= a_sr >> 1;
               b_sr  <= b_sr >> 1;
               sum_r <= {fa_s, sum_r[WIDTH-1:1]};
               carry <= fa_c;
               cnt   <= cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.sum = sum_r;
   assign bus.co  = carry;

`ifdef SERIAL_ADDER_OVF_EN
   logic a_msb;
   logic b_msb;
   logic ovf_r;

   // operand MSBs are shifted away, so keep copies for the final compare
   always_ff @(posedge clk) begin
      if (rst) begin
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         ovf_r <= 1'b0;
      end else if (state == IDLE && bus.start) begin
         a_msb <= bus.a[WIDTH-1];
         b_msb <= bus.b[WIDTH-1];
      end else if (state == SHIFT && last) begin
         ovf_r <= (a_msb == b_msb) && (fa_s != a_msb);
      end
   end

   assign bus.ovf = ovf_r;
`endif
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8, plus WIDTH=4 when
// SERIAL_ADDER_OVF_EN is defined).
module tb_serial_adder;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst;
   int   vec = 0;
   int   err = 0;

   serial_adder_if #(.WIDTH(W)) bus ();
   serial_adder #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

`ifdef SERIAL_ADDER_OVF_EN
   serial_adder_if #(.WIDTH(4)) bus4 ();
   serial_adder #(.WIDTH(4)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4)
   );
`endif

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      vec++;
      if (got !== exp) begin
         err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic run_add(input string tag,
                          input logic [7:0] a,
                          input logic [7:0] b,
                          input logic ci,
                          input logic [7:0] es,
                          input logic eco,
                          input logic eovf,
                          input bit jam);
      int lat;
      int busy_n;
      int done_n;
      bit seen;
      @(negedge clk);
      bus.start = 1'b1;
      bus.a = a;
      bus.b = b;
      bus.ci = ci;
      @(posedge clk);
      lat = 0;
      busy_n = 0;
      seen = 0;
      while (!seen && lat < 4 * W) begin
         @(negedge clk);
         lat++;
         if (jam) begin
            bus.start = (lat == 4);
            bus.a = 8'($urandom);
            bus.b = 8'($urandom);
            bus.ci = 1'($urandom);
         end else begin
            bus.start = 1'b0;
         end
         if (bus.busy) busy_n++;
         if (bus.done) seen = 1;
      end
      bus.start = 1'b0;
      chk({tag, " latency"}, lat, W + 1);
      chk({tag, " busy"}, busy_n, W);
      chk({tag, " sum"}, bus.sum, es);
      chk({tag, " co"}, bus.co, eco);
`ifdef SERIAL_ADDER_OVF_EN
      chk({tag, " ovf"}, bus.ovf, eovf);
`else
      if (eovf === 1'bx) $display("bad ovf arg");
`endif
      done_n = 0;
      busy_n = 0;
      repeat (W + 4) begin
         @(negedge clk);
         if (bus.done) done_n++;
         if (bus.busy) busy_n++;
      end
      chk({tag, " extra done"}, done_n, 0);
      chk({tag, " restart"}, busy_n, 0);
      chk({tag, " sum hold"}, bus.sum, es);
   endtask

   initial begin
      int n;
      int dn;
      rst = 1'b1;
      bus.start = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.ci = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      bus4.start = 1'b0;
      bus4.a = '0;
      bus4.b = '0;
      bus4.ci = 1'b0;
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst busy", bus.busy, 0);
      chk("rst done", bus.done, 0);
      chk("rst sum", bus.sum, 0);
      chk("rst co", bus.co, 0);
`ifdef SERIAL_ADDER_OVF_EN
      chk("rst ovf", bus.ovf, 0);
`endif
      rst = 1'b0;

      run_add("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 0);
      run_add("ff+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
      run_add("a5+5a", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, 0);
      run_add("jam", 8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0, 1'b0, 1);

      // abort mid-SHIFT: rst sampled on the 4th SHIFT edge
      @(negedge clk);
      bus.start = 1'b1;
      bus.a = 8'hFF;
      bus.b = 8'hFF;
      bus.ci = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort busy", bus.busy, 0);
      chk("abort done", bus.done, 0);
      chk("abort sum", bus.sum, 0);
      chk("abort co", bus.co, 0);
      dn = 0;
      repeat (W + 4) begin
         @(negedge clk);
         if (bus.done) dn++;
      end
      chk("abort no done", dn, 0);
      run_add("12+34", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 0);

      // start held high: back-to-back adds
      @(negedge clk);
      bus.start = 1'b1;
      bus.a = 8'h80;
      bus.b = 8'h80;
      bus.ci = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.done && n < 40);
      chk("held first", n, W + 1);
      for (int i = 0; i < 3; i++) begin
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!bus.done && n < 40);
         chk("held period", n, W + 2);
         chk("held sum", bus.sum, 8'h00);
         chk("held co", bus.co, 1'b1);
`ifdef SERIAL_ADDER_OVF_EN
         chk("held ovf", bus.ovf, 1'b1);
`endif
      end
      bus.start = 1'b0;
      repeat (W + 4) @(negedge clk);

`ifdef SERIAL_ADDER_OVF_EN
      run_add("7f+01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0);
      run_add("ff+01o", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
      @(negedge clk);
      bus4.start = 1'b1;
      bus4.a = 4'h8;
      bus4.b = 4'h8;
      bus4.ci = 1'b0;
      @(posedge clk);
      n = 0;
      do begin
         @(negedge clk);
         bus4.start = 1'b0;
         n++;
      end while (!bus4.done && n < 20);
      chk("w4 latency", n, 5);
      chk("w4 sum", bus4.sum, 4'h0);
      chk("w4 co", bus4.co, 1'b1);
      chk("w4 ovf", bus4.ovf, 1'b1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end
endmodule
